// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with an internal FIFO. The frame format and
// baud divisor are captured when a byte is popped, so they stay fixed for that frame.
module uart_tx_cfg #(
  parameter int FIFO_DEPTH = 32,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIV_WIDTH-1:0]          baud_div_i,
  input  logic [1:0]                    data_bits_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          we_i,
  input  logic [7:0]                    data_i,
  input  logic                          stall_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          busy_o,
  output logic                          tx_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } state_t;

  // Low-N-bit mask for the configured character length (5..8 bits).
  function automatic logic [7:0] data_mask(input logic [1:0] dbits);
    return 8'hFF >> (2'd3 - dbits);
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] dbits,
                                      input logic odd);
    return (^(d & data_mask(dbits))) ^ odd;
  endfunction

  logic [7:0]           mem [FIFO_DEPTH];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic [7:0]           head;
  logic                 push;
  logic                 pop;

  state_t               state;
  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_l;
  logic [7:0]           sh;
  logic [2:0]           bitcnt;
  logic [1:0]           dbits_l;
  logic                 par_en_l;
  logic                 par_l;
  logic                 stop2_l;
  logic                 bit_end;
  logic                 last_stop;
  logic [2:0]           last_idx;

  // Pointers carry an extra wrap bit so a full FIFO is distinguishable from empty.
  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level_o = wptr - rptr;
  assign head    = mem[rptr[AW-1:0]];

  assign bit_end   = (cnt == '0);
  assign last_stop = bit_end && (((state == STOP1) && !stop2_l) || (state == STOP2));
  assign last_idx  = {1'b1, dbits_l};

  assign push = we_i && !full_o;
  assign pop  = !empty_o && !stall_i && ((state == IDLE) || last_stop);

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + (AW+1)'(1);
      end
      if (pop) begin
        rptr <= rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      tx_o   <= 1'b1;
      busy_o <= 1'b0;
    end else if (pop) begin
      state    <= START;
      tx_o     <= 1'b0;
      busy_o   <= 1'b1;
      sh       <= head;
      dbits_l  <= data_bits_i;
      par_en_l <= parity_i[0] ^ parity_i[1];
      par_l    <= parity_bit(head, data_bits_i, parity_i[1]);
      stop2_l  <= stop2_i;
      div_l    <= baud_div_i;
      cnt      <= baud_div_i;
    end else if (state != IDLE) begin
      if (!bit_end) begin
        cnt <= cnt - DIV_WIDTH'(1);
      end else begin
        cnt <= div_l;
        unique case (state)
          START: begin
            state  <= DATA;
            tx_o   <= sh[0];
            bitcnt <= 3'd0;
          end
          DATA: begin
            if (bitcnt == last_idx) begin
              if (par_en_l) begin
                state <= PARITY;
                tx_o  <= par_l;
              end else begin
                state <= STOP1;
                tx_o  <= 1'b1;
              end
            end else begin
              bitcnt <= bitcnt + 3'd1;
              sh     <= sh >> 1;
              tx_o   <= sh[1];
            end
          end
          PARITY: begin
            state <= STOP1;
            tx_o  <= 1'b1;
          end
          STOP1: begin
            tx_o <= 1'b1;
            if (stop2_l) begin
              state <= STOP2;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end
          STOP2: begin
            state  <= IDLE;
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame shape, parity, FIFO limits,
// back-to-back frames, mid-frame config changes and reset abort.
module tb_uart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  data_bits;
  logic [1:0]  parity;
  logic        stop2;
  logic        we;
  logic [7:0]  data;
  logic        stall;
  logic        full;
  logic        empty;
  logic [2:0]  level;
  logic        busy;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;
  int waited;
  int ones_cnt;

  uart_tx_cfg #(.FIFO_DEPTH(4), .DIV_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .data_bits_i(data_bits),
    .parity_i(parity), .stop2_i(stop2), .we_i(we), .data_i(data),
    .stall_i(stall), .full_o(full), .empty_o(empty), .level_o(level),
    .busy_o(busy), .tx_o(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; leaves the caller at the next negedge.
  task automatic write_byte(input logic [7:0] d);
    we   = 1'b1;
    data = d;
    @(negedge clk);
    we   = 1'b0;
  endtask

  // Waits for the start bit, then checks every bit's value and duration.
  // pmode: 0 none, 1 even, 2 odd. Ends at the negedge after the last stop cycle.
  task automatic run_frame(input string tag, input logic [7:0] d, input int n,
                           input int pmode, input int nstop, input int div,
                           input bit idle_after, output int wt);
    logic exp_bits[12];
    int len, ones, t, good, busy_cnt;
    len = 0; ones = 0; t = 0; busy_cnt = 0;
    exp_bits[len] = 1'b0; len++;
    for (int i = 0; i < n; i++) begin
      exp_bits[len] = d[i]; len++;
      if (d[i]) ones++;
    end
    if (pmode == 1) begin exp_bits[len] = (ones % 2 == 1); len++; end
    if (pmode == 2) begin exp_bits[len] = (ones % 2 == 0); len++; end
    for (int i = 0; i < nstop; i++) begin exp_bits[len] = 1'b1; len++; end
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    wt = t;
    check({tag, "_start"}, {31'd0, tx}, 32'd0);
    if (tx !== 1'b0) return;
    for (int b = 0; b < len; b++) begin
      good = 0;
      for (int c = 0; c <= div; c++) begin
        if (tx === exp_bits[b]) good++;
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d", tag, b), good, div + 1);
    end
    check({tag, "_busy_cycles"}, busy_cnt, len * (div + 1));
    if (idle_after) begin
      check({tag, "_idle_tx"}, {31'd0, tx}, 32'd1);
      check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; baud_div = 16'd0; data_bits = 2'b11; parity = 2'b00;
    stop2 = 1'b0; we = 1'b0; data = 8'h00; stall = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_level", {29'd0, level}, 32'd0);

    // 8N1, 4 cycles per bit, 0xA5
    baud_div = 16'd3; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
    write_byte(8'hA5);
    run_frame("a5_8n1", 8'hA5, 8, 0, 1, 3, 1'b1, waited);

    // 7 data bits, 0x41, even then odd parity with two stop bits
    baud_div = 16'd1; data_bits = 2'b10; parity = 2'b01; stop2 = 1'b0;
    write_byte(8'h41);
    run_frame("p7e1", 8'h41, 7, 1, 1, 1, 1'b1, waited);
    parity = 2'b10; stop2 = 1'b1;
    write_byte(8'h41);
    run_frame("p7o2", 8'h41, 7, 2, 2, 1, 1'b1, waited);
    ones_cnt = 0;
    for (int i = 0; i < 7; i++) if (dut.sh[i]) ones_cnt++;

    // FIFO fill under stall; fifth write and a write during the first pop are dropped
    baud_div = 16'd0; data_bits = 2'b11; parity = 2'b00; stop2 = 1'b0;
    stall = 1'b1;
    write_byte(8'h11);
    check("fill1_level", {29'd0, level}, 32'd1);
    check("fill1_empty", {31'd0, empty}, 32'd0);
    write_byte(8'h22);
    write_byte(8'h33);
    check("fill3_full", {31'd0, full}, 32'd0);
    write_byte(8'h44);
    check("fill4_full", {31'd0, full}, 32'd1);
    check("fill4_level", {29'd0, level}, 32'd4);
    write_byte(8'h55);
    check("fill5_level", {29'd0, level}, 32'd4);
    check("stall_tx", {31'd0, tx}, 32'd1);
    check("stall_busy", {31'd0, busy}, 32'd0);
    stall = 1'b0;
    write_byte(8'h66);
    check("full_pop_level", {29'd0, level}, 32'd3);
    run_frame("fifo0", 8'h11, 8, 0, 1, 0, 1'b0, waited);
    run_frame("fifo1", 8'h22, 8, 0, 1, 0, 1'b0, waited);
    check("fifo1_gap", waited, 0);
    run_frame("fifo2", 8'h33, 8, 0, 1, 0, 1'b0, waited);
    check("fifo2_gap", waited, 0);
    run_frame("fifo3", 8'h44, 8, 0, 1, 0, 1'b1, waited);
    check("fifo3_gap", waited, 0);
    check("fifo_drained", {31'd0, empty}, 32'd1);

    // Back-to-back writes, divisor 0; simultaneous write+pop keeps the level
    we = 1'b1; data = 8'h0F;
    @(negedge clk);
    data = 8'hF0;
    @(negedge clk);
    we = 1'b0;
    check("wr_pop_level", {29'd0, level}, 32'd1);
    run_frame("b2b0", 8'h0F, 8, 0, 1, 0, 1'b0, waited);
    run_frame("b2b1", 8'hF0, 8, 0, 1, 0, 1'b1, waited);
    check("b2b_gap", waited, 0);

    // Config change mid-frame affects only the next frame
    baud_div = 16'd2; data_bits = 2'b11;
    we = 1'b1; data = 8'h5A;
    @(negedge clk);
    data = 8'hF3;
    @(negedge clk);
    we = 1'b0;
    fork
      begin
        repeat (5) @(negedge clk);
        baud_div  = 16'd0;
        data_bits = 2'b00;
      end
    join_none
    run_frame("cfg_old", 8'h5A, 8, 0, 1, 2, 1'b0, waited);
    run_frame("cfg_new", 8'hF3, 5, 0, 1, 0, 1'b1, waited);
    check("cfg_gap", waited, 0);

    // Reset during DATA aborts the frame and flushes the queued byte
    baud_div = 16'd3; data_bits = 2'b11;
    we = 1'b1; data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    we = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_level", {29'd0, level}, 32'd0);
    check("abort_empty", {31'd0, empty}, 32'd1);
    check("abort_full", {31'd0, full}, 32'd0);
    waited = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx === 1'b1 && busy === 1'b0) waited++;
      @(negedge clk);
    end
    check("abort_quiet", waited, 60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 32, meaning transmit FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter DIV_WIDTH, default 16, meaning width of the baud divisor.
REQ-003 SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port baud_div_i  input  DIV_WIDTH  bit period minus one, in clk_i cycles.
REQ-006 SHALL have port data_bits_i  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
REQ-007 SHALL have port parity_i  input  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
REQ-008 SHALL have port stop2_i  input  1  stop bits: 0=one, 1=two.
REQ-009 SHALL have port we_i  input  1  write strobe; pushes data_i when not full.
REQ-010 SHALL have port data_i  input  8  byte to queue; only the low N bits are sent, LSB first.
REQ-011 SHALL have port stall_i  input  1  when high, no new frame starts; a frame in progress completes.
REQ-012 SHALL have port full_o  input-side status  output  1  FIFO holds FIFO_DEPTH entries.
REQ-013 SHALL have port empty_o  output  1  FIFO holds zero entries.
REQ-014 SHALL have port level_o  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-015 SHALL have port busy_o  output  1  high from the first start-bit cycle to the last stop-bit cycle.
REQ-016 SHALL have port tx_o  output  1  registered serial line; idle high.

Function
REQ-017 SHALL implement the FIFO with pointers one bit wider than the address, so all FIFO_DEPTH entries are usable.
REQ-018 SHALL ignore we_i while full_o is high, even when a pop occurs in the same cycle; no overwrite and no pointer change.
REQ-019 SHALL leave level_o unchanged when a write and a pop occur in the same cycle.
REQ-020 SHALL use the states IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-021 SHALL, in IDLE with empty_o low and stall_i low, pop the head entry and enter START on the next cycle.
REQ-022 SHALL, at the pop, latch the byte, data_bits_i, parity_i, stop2_i and baud_div_i; input changes mid-frame SHALL not affect the current frame.
REQ-023 SHALL restart the baud counter at the pop, so every bit lasts exactly baud_div_i+1 cycles; baud_div_i=0 gives one cycle per bit.
REQ-024 SHALL drive tx_o as follows: START=0; DATA=bits 0..N-1 in order; PARITY=parity bit; STOP1 and STOP2=1.
REQ-025 SHALL compute the parity bit over the N sent bits only: even makes the total count of ones even; odd makes it odd.
REQ-026 SHALL skip the PARITY state when parity is none, and skip STOP2 when stop2 is 0.
REQ-027 SHALL, at the end of the last stop bit, enter START directly on the next cycle if the FIFO is non-empty and stall_i is low (no idle gap); otherwise it SHALL enter IDLE.
REQ-028 SHALL have a frame length of 1+N+P+S bits, each of baud_div_i+1 cycles, where P is 0 or 1 for parity and S is 1 or 2 stop bits.
REQ-029 SHALL sample stall_i only at frame-start decision points.

Reset
REQ-030 SHALL, in the cycle after rst_i is sampled high, set tx_o=1, busy_o=0, empty_o=1, full_o=0, level_o=0 and state=IDLE.
REQ-031 SHALL, on reset mid-frame, abort the frame immediately, flush the FIFO and drop the in-flight byte.
REQ-032 SHALL not require FIFO storage contents to be reset.

Verification
REQ-033 SHALL cover: baud_div=3, 8N1, write 0xA5 -> tx_o reads 0 then 1,0,1,0,0,1,0,1 then 1, with 4 cycles per bit; busy_o high for 40 cycles.
REQ-034 SHALL cover: 7 data bits with 0x41 -> even parity gives parity bit 0 and odd parity gives 1; with stop2=1 the frame is 11 bits.
REQ-035 SHALL cover: FIFO_DEPTH=4, five writes with stall_i high -> full_o after the 4th write, the 5th write dropped, level_o=4, and 4 frames sent in order once stall_i goes low.
REQ-036 SHALL cover: writing 2 bytes with baud_div=0 -> the second start bit follows the first stop bit with no idle cycle.
REQ-037 SHALL cover: change data_bits_i and baud_div_i mid-frame -> the current frame is unchanged and the next frame uses the new values.
REQ-038 SHALL cover: rst_i pulsed during DATA -> tx_o=1, level_o=0, busy_o=0 on the next cycle, and no further output until a new write.
